uart_matrix_rx: RTL and testbench

- UART 8N1 receiver plus matrix assembler; the host-to-board counterpart of the result transmitter on TxD.
- Receives 18 bytes on RxD: 9 bytes for matrix A, then 9 bytes for matrix B.
- Packs them into the 72-bit A/B operand format that matrix_mult consumes.
- Presents both matrices with a valid/ack handshake, so the top-level state machine can start the multiplier on host-supplied data instead of hard-coded constants.

---
 rtl/uart_matrix_rx.sv | 187 ++++++++++++++++++
 tb/tb_uart_matrix_rx.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/uart_matrix_rx.sv
// uart_matrix_rx: UART 8N1 receiver that assembles 18 host bytes into the
// 72-bit A and B operands for matrix_mult, handed over via valid/ack.
//
// Ports
//   Clock      : system clock, rising edge
//   reset      : asynchronous active-low reset
//   RxD        : UART serial input, idle high, asynchronous to Clock
//   mat_ack    : consumer accepted A/B (sampled only while mat_valid=1)
//   A, B       : matrices, element k at bits [8k+7:8k]
//   mat_valid  : A and B complete and stable
//   frame_err  : one-cycle pulse on a bad stop bit
//   overrun    : sticky, byte arrived while mat_valid=1
//   byte_count : bytes accepted in the current load (0..18)
module uart_matrix_rx #(
    parameter int unsigned CLKS_PER_BIT = 10417,
    parameter int unsigned TIMEOUT_BITS = 20
) (
    input  logic        Clock,
    input  logic        reset,
    input  logic        RxD,
    input  logic        mat_ack,
    output logic [71:0] A,
    output logic [71:0] B,
    output logic        mat_valid,
    output logic        frame_err,
    output logic        overrun,
    output logic [4:0]  byte_count
);

    localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int unsigned TO_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int unsigned TO_W   = $clog2(TO_CYC + 1);

    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TO_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_e;

    logic             sync1_q, sync2_q;
    logic             rx_s;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             strobe_q, strobe_d;
    logic             ferr_q, ferr_d;
    logic [71:0]      a_q, a_d, b_q, b_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic [4:0]       count_q, count_d;
    logic [TO_W-1:0]  idle_q, idle_d;
    logic [6:0]       a_pos, b_pos;

    assign rx_s = sync2_q;

    // RX bit-level FSM
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        strobe_d = 1'b0;
        ferr_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!rx_s) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == HALF_CNT) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    // A start bit that has gone high again by mid-bit is a glitch
                    state_d = rx_s ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == LAST_CNT) begin
                    shift_d[idx_q] = rx_s;
                    cnt_d          = '0;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                // Leave mid-stop-bit so back-to-back frames are caught
                if (cnt_q == LAST_CNT) begin
                    strobe_d = rx_s;
                    ferr_d   = !rx_s;
                    cnt_d    = '0;
                    state_d  = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Byte assembler, handshake and partial-load timeout
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        count_d = count_q;
        idle_d  = idle_q;
        a_pos   = {count_q[3:0], 3'b000};
        b_pos   = {4'(count_q - 5'd9), 3'b000};

        if (valid_q) begin
            // A byte landing on the ack edge is still treated as an overrun
            if (strobe_q) ovr_d = 1'b1;
            if (mat_ack) begin
                valid_d = 1'b0;
                count_d = '0;
            end
        end else if (strobe_q) begin
            if (count_q < 5'd9) a_d[a_pos +: 8] = shift_q;
            else                b_d[b_pos +: 8] = shift_q;
            count_d = count_q + 5'd1;
            if (count_q == 5'd17) valid_d = 1'b1;
        end

        if (strobe_q || state_q != S_IDLE || count_q == 5'd0 || count_q >= 5'd18 || valid_q) begin
            idle_d = '0;
        end else if (idle_q == TO_LAST) begin
            idle_d  = '0;
            count_d = '0;
        end else begin
            idle_d = idle_q + TO_W'(1);
        end
    end

    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            strobe_q <= 1'b0;
            ferr_q   <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
            count_q  <= '0;
            idle_q   <= '0;
        end else begin
            sync1_q  <= RxD;
            sync2_q  <= sync1_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            strobe_q <= strobe_d;
            ferr_q   <= ferr_d;
            a_q      <= a_d;
            b_q      <= b_d;
            valid_q  <= valid_d;
            ovr_q    <= ovr_d;
            count_q  <= count_d;
            idle_q   <= idle_d;
        end
    end

    assign A          = a_q;
    assign B          = b_q;
    assign mat_valid  = valid_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;
    assign byte_count = count_q;

endmodule

// File: tb/tb_uart_matrix_rx.sv
// Self-checking bench for uart_matrix_rx with a byte-level reference model.
module tb_uart_matrix_rx;

    localparam int unsigned CPB = 16;
    localparam int unsigned TOB = 20;

    logic        Clock;
    logic        reset;
    logic        RxD;
    logic        mat_ack;
    logic [71:0] A, B;
    logic        mat_valid, frame_err, overrun;
    logic [4:0]  byte_count;

    uart_matrix_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
        .Clock      (Clock),
        .reset      (reset),
        .RxD        (RxD),
        .mat_ack    (mat_ack),
        .A          (A),
        .B          (B),
        .mat_valid  (mat_valid),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .byte_count (byte_count)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int n_chk  = 0;
    int n_fail = 0;
    int ferr_cnt = 0;

    always @(posedge Clock) if (frame_err) ferr_cnt <= ferr_cnt + 1;

    // Reference model: plain byte list semantics of an 18-byte load
    logic [71:0] exp_a, exp_b;
    logic        exp_valid, exp_ovr;
    int          exp_cnt;

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_a = '0; exp_b = '0; exp_valid = 1'b0; exp_ovr = 1'b0; exp_cnt = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (exp_valid) begin
            exp_ovr = 1'b1;
        end else begin
            if (exp_cnt < 9) exp_a[8*exp_cnt +: 8] = b;
            else             exp_b[8*(exp_cnt-9) +: 8] = b;
            exp_cnt++;
            if (exp_cnt == 18) exp_valid = 1'b1;
        end
    endtask

    // One 8N1 frame plus idle gap; a bad stop bit is held low only long
    // enough to cover the receiver's mid-bit sample.
    task automatic send_frame(input logic [7:0] b, input logic stop_ok);
        @(negedge Clock);
        RxD = 1'b0;
        repeat (CPB) @(negedge Clock);
        for (int i = 0; i < 8; i++) begin
            RxD = b[i];
            repeat (CPB) @(negedge Clock);
        end
        RxD = stop_ok;
        repeat (stop_ok ? CPB : 12) @(negedge Clock);
        RxD = 1'b1;
        repeat (stop_ok ? 20 : 24) @(negedge Clock);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b1);
        model_byte(b);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".A"}, A, exp_a);
        chk({tag, ".B"}, B, exp_b);
        chk({tag, ".valid"}, 72'(mat_valid), 72'(exp_valid));
        chk({tag, ".count"}, 72'(byte_count), 72'(exp_cnt));
        chk({tag, ".overrun"}, 72'(overrun), 72'(exp_ovr));
    endtask

    task automatic do_ack();
        @(negedge Clock);
        mat_ack = 1'b1;
        @(negedge Clock);
        mat_ack = 1'b0;
        exp_valid = 1'b0;
        exp_cnt   = 0;
    endtask

    task automatic random_load();
        for (int i = 0; i < 18; i++) send_byte(8'($urandom_range(0, 255)));
    endtask

    int          f0;
    logic [7:0]  rb;

    initial begin
        reset = 1'b0; RxD = 1'b1; mat_ack = 1'b0;
        model_reset();
        repeat (3) @(negedge Clock);
        check_all("reset");
        chk("reset.ferr", 72'(frame_err), 72'd0);
        reset = 1'b1;
        repeat (5) @(negedge Clock);

        // Directed load
        for (int i = 1; i <= 9; i++) send_byte(8'(i));
        for (int i = 2; i <= 9; i++) send_byte(8'(i));
        send_byte(8'd1);
        check_all("load1");
        chk("load1.Aconst", A, 72'h090807060504030201);
        chk("load1.Bconst", B, 72'h010908070605040302);
        do_ack();
        check_all("ack1");

        // Short low glitch on idle line
        f0 = ferr_cnt;
        @(negedge Clock);
        RxD = 1'b0;
        repeat (5) @(negedge Clock);
        RxD = 1'b1;
        repeat (40) @(negedge Clock);
        check_all("glitch");
        chk("glitch.ferr", 72'(ferr_cnt - f0), 72'd0);

        // Bad stop bit, then a good byte
        f0 = ferr_cnt;
        send_frame(8'h55, 1'b0);
        chk("ferr.pulses", 72'(ferr_cnt - f0), 72'd1);
        check_all("ferr");
        send_byte(8'hA5);
        chk("ferr.A0", 72'(A[7:0]), 72'hA5);
        check_all("after_ferr");

        // Partial load then timeout
        for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(0, 255)));
        chk("partial.count", 72'(byte_count), 72'd4);
        repeat (280) @(negedge Clock);
        chk("pre_timeout.count", 72'(byte_count), 72'd4);
        repeat (50) @(negedge Clock);
        exp_cnt = 0;
        chk("timeout.count", 72'(byte_count), 72'd0);

        // Fresh random load from element 0
        random_load();
        check_all("load2");
        do_ack();
        check_all("ack2");

        // Full load, withhold ack, extra byte overruns
        random_load();
        check_all("load3");
        send_byte(8'hFF);
        check_all("overrun");
        do_ack();
        check_all("ack3");

        // Reset during data bit 3
        rb = 8'($urandom_range(0, 255));
        @(negedge Clock);
        RxD = 1'b0;
        repeat (CPB) @(negedge Clock);
        for (int i = 0; i < 3; i++) begin
            RxD = rb[i];
            repeat (CPB) @(negedge Clock);
        end
        RxD = rb[3];
        repeat (8) @(negedge Clock);
        reset = 1'b0;
        #1;
        model_reset();
        check_all("midreset");
        chk("midreset.ferr", 72'(frame_err), 72'd0);
        RxD = 1'b1;
        repeat (5) @(negedge Clock);
        reset = 1'b1;
        repeat (5) @(negedge Clock);
        send_byte(8'($urandom_range(0, 255)));
        check_all("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
